// File: rtl/retro_cache_line_sequencer.sv
// Cache line miss sequencer: optional dirty-victim writeback, full-line fill into BRAM, tag commit.
// Build option: RETRO_CACHE_CRITICAL_WORD_FIRST_EN starts both transfers at the missed byte and wraps.
module retro_cache_line_sequencer #(
  parameter int unsigned AddressBusWidth = 16,
  parameter int unsigned CacheLineBits   = 7,
  parameter int unsigned CacheIndexBits  = 7,
  localparam int unsigned TagLength      = AddressBusWidth - CacheIndexBits - CacheLineBits,
  localparam int unsigned StoAddrWidth   = CacheIndexBits + CacheLineBits
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       MissReq,
  input  logic [TagLength-1:0]       MissTag,
  input  logic [CacheIndexBits-1:0]  MissIndex,
  input  logic [CacheLineBits-1:0]   MissOffset,
  input  logic                       VictimValid,
  input  logic                       VictimDirty,
  input  logic [TagLength-1:0]       VictimTag,
  output logic                       Delay,
  output logic                       Done,
  output logic                       TagWrite,
  output logic [CacheIndexBits-1:0]  TagIndex,
  output logic [TagLength-1:0]       TagValue,
  output logic [AddressBusWidth-1:0] SrcAddress,
  output logic                       SrcAccess,
  output logic                       SrcWrite,
  output logic [7:0]                 SrcDout,
  input  logic [7:0]                 SrcDin,
  input  logic                       SrcReady,
  output logic [StoAddrWidth-1:0]    StoAddress,
  output logic                       StoAccess,
  output logic                       StoWrite,
  output logic [7:0]                 StoDout,
  input  logic [7:0]                 StoDin
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_RD   = 3'd1,
    WB_WR   = 3'd2,
    FILL_RD = 3'd3,
    FILL_WR = 3'd4,
    COMMIT  = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [CacheLineBits-1:0]  ctr_q, ctr_d;
  logic [CacheLineBits-1:0]  start_q, start_d;
  logic [CacheIndexBits-1:0] index_q, index_d;
  logic [TagLength-1:0]      mtag_q, mtag_d;
  logic [TagLength-1:0]      vtag_q, vtag_d;
  logic [7:0]                data_q, data_d;
  logic                      wb_first_q, wb_first_d;

  logic [CacheLineBits-1:0]  start_offset_c;
  logic [CacheLineBits-1:0]  last_off_c;
  logic                      last_c;

`ifdef RETRO_CACHE_CRITICAL_WORD_FIRST_EN
  assign start_offset_c = MissOffset;
`else
  logic unused_miss_offset;
  assign unused_miss_offset = ^MissOffset;
  assign start_offset_c     = '0;
`endif

  // Last byte of the line is the one just before the start offset, modulo line size.
  assign last_off_c = start_q - CacheLineBits'(1);
  assign last_c     = (ctr_q == last_off_c);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctr_q      <= '0;
      start_q    <= '0;
      index_q    <= '0;
      mtag_q     <= '0;
      vtag_q     <= '0;
      data_q     <= '0;
      wb_first_q <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      start_q    <= start_d;
      index_q    <= index_d;
      mtag_q     <= mtag_d;
      vtag_q     <= vtag_d;
      data_q     <= data_d;
      wb_first_q <= wb_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    start_d    = start_q;
    index_d    = index_q;
    mtag_d     = mtag_q;
    vtag_d     = vtag_q;
    data_d     = data_q;
    wb_first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MissReq) begin
          mtag_d  = MissTag;
          index_d = MissIndex;
          vtag_d  = VictimTag;
          start_d = start_offset_c;
          ctr_d   = start_offset_c;
          state_d = (VictimValid && VictimDirty) ? WB_RD : FILL_RD;
        end
      end
      WB_RD: begin
        wb_first_d = 1'b1;
        state_d    = WB_WR;
      end
      WB_WR: begin
        // BRAM data is only guaranteed in the first WB_WR cycle; hold it across source waits.
        if (wb_first_q) data_d = StoDin;
        if (SrcReady) begin
          if (last_c) begin
            ctr_d   = start_q;
            state_d = FILL_RD;
          end else begin
            ctr_d   = ctr_q + CacheLineBits'(1);
            state_d = WB_RD;
          end
        end
      end
      FILL_RD: begin
        if (SrcReady) begin
          data_d  = SrcDin;
          state_d = FILL_WR;
        end
      end
      FILL_WR: begin
        ctr_d   = ctr_q + CacheLineBits'(1);
        state_d = last_c ? COMMIT : FILL_RD;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    Delay      = (state_q != IDLE);
    Done       = 1'b0;
    TagWrite   = 1'b0;
    TagIndex   = '0;
    TagValue   = '0;
    SrcAddress = '0;
    SrcAccess  = 1'b0;
    SrcWrite   = 1'b0;
    SrcDout    = '0;
    StoAddress = '0;
    StoAccess  = 1'b0;
    StoWrite   = 1'b0;
    StoDout    = '0;
    unique case (state_q)
      WB_RD: begin
        StoAccess  = 1'b1;
        StoAddress = {index_q, ctr_q};
      end
      WB_WR: begin
        SrcAccess  = 1'b1;
        SrcWrite   = 1'b1;
        SrcAddress = {vtag_q, index_q, ctr_q};
        SrcDout    = wb_first_q ? StoDin : data_q;
      end
      FILL_RD: begin
        SrcAccess  = 1'b1;
        SrcAddress = {mtag_q, index_q, ctr_q};
      end
      FILL_WR: begin
        StoAccess  = 1'b1;
        StoWrite   = 1'b1;
        StoAddress = {index_q, ctr_q};
        StoDout    = data_q;
      end
      COMMIT: begin
        TagWrite = 1'b1;
        TagIndex = index_q;
        TagValue = mtag_q;
        Done     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_retro_cache_line_sequencer.sv
// Scoreboard bench for retro_cache_line_sequencer: expected source/BRAM/tag events queued per miss,
// a negedge monitor pops and compares each event the DUT presents.
module tb_retro_cache_line_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MissReq;
  logic [1:0]  MissTag;
  logic [6:0]  MissIndex;
  logic [6:0]  MissOffset;
  logic        VictimValid;
  logic        VictimDirty;
  logic [1:0]  VictimTag;
  logic        Delay;
  logic        Done;
  logic        TagWrite;
  logic [6:0]  TagIndex;
  logic [1:0]  TagValue;
  logic [15:0] SrcAddress;
  logic        SrcAccess;
  logic        SrcWrite;
  logic [7:0]  SrcDout;
  logic [7:0]  SrcDin;
  logic        SrcReady;
  logic [13:0] StoAddress;
  logic        StoAccess;
  logic        StoWrite;
  logic [7:0]  StoDout;
  logic [7:0]  StoDin = 8'd0;

  retro_cache_line_sequencer dut (
    .Clk(Clk), .Reset(Reset), .MissReq(MissReq), .MissTag(MissTag), .MissIndex(MissIndex),
    .MissOffset(MissOffset), .VictimValid(VictimValid), .VictimDirty(VictimDirty),
    .VictimTag(VictimTag), .Delay(Delay), .Done(Done), .TagWrite(TagWrite),
    .TagIndex(TagIndex), .TagValue(TagValue), .SrcAddress(SrcAddress), .SrcAccess(SrcAccess),
    .SrcWrite(SrcWrite), .SrcDout(SrcDout), .SrcDin(SrcDin), .SrcReady(SrcReady),
    .StoAddress(StoAddress), .StoAccess(StoAccess), .StoWrite(StoWrite), .StoDout(StoDout),
    .StoDin(StoDin)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          kind;   // 0 src write, 1 src read, 2 bram write, 3 commit
    logic [15:0] addr;
    logic [7:0]  data;
    int          lat;
  } ev_t;

  ev_t q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  start_cyc = 0;
  int  wait_states = 0;
  int  wcnt = 0;
  logic delay_prev = 1'b0;
  logic after_done = 1'b0;
  logic [7:0] bram [0:16383];

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Source model: SrcReady after wait_states idle cycles of a held access.
  assign SrcReady = SrcAccess && (wcnt >= wait_states);
  assign SrcDin   = src_byte(SrcAddress);
  always @(posedge Clk) wcnt <= (SrcAccess && !SrcReady) ? wcnt + 1 : 0;

  // BRAM model with one-cycle read latency.
  always @(posedge Clk) begin
    if (StoAccess && !StoWrite) StoDin <= bram[StoAddress];
    if (StoAccess && StoWrite)  bram[StoAddress] <= StoDout;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind, input logic [15:0] addr, input logic [7:0] data);
    ev_t e;
    logic ok;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d addr=%h data=%h, expected no event", kind, addr, data);
      return;
    end
    e  = q.pop_front();
    ok = (e.kind == kind) && (e.addr == addr) && (kind == 1 || e.data == data) && Delay;
    if (!ok) begin
      n_fail++;
      $display("FAIL event: got kind=%0d addr=%h data=%h delay=%b, expected kind=%0d addr=%h data=%h delay=1",
               kind, addr, data, Delay, e.kind, e.addr, e.data);
    end
  endtask

  task automatic check_commit();
    ev_t e;
    int  lat;
    logic ok;
    lat = cyc - start_cyc + 1;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_commit: tagwrite=%b done=%b index=%h, expected none", TagWrite, Done, TagIndex);
      return;
    end
    e  = q.pop_front();
    ok = (e.kind == 3) && TagWrite && Done && (TagIndex == e.addr[6:0]) &&
         (TagValue == e.data[1:0]) && (lat == e.lat);
    if (!ok) begin
      n_fail++;
      $display("FAIL commit: got kind=3 tw=%b done=%b idx=%h tag=%h lat=%0d, expected kind=%0d tw=1 done=1 idx=%h tag=%h lat=%0d",
               TagWrite, Done, TagIndex, TagValue, lat, e.kind, e.addr[6:0], e.data[1:0], e.lat);
    end
  endtask

  // Monitor
  always @(negedge Clk) begin
    if (after_done) begin
      chk("post_done_idle", {29'd0, Delay, Done, TagWrite}, 0);
      after_done = 1'b0;
    end
    if (Delay && !delay_prev) start_cyc = cyc;
    delay_prev = Delay;
    if (SrcAccess && SrcReady) check_ev(SrcWrite ? 0 : 1, SrcAddress, SrcDout);
    if (StoAccess && StoWrite) check_ev(2, {2'b00, StoAddress}, StoDout);
    if (TagWrite || Done) begin
      check_commit();
      after_done = 1'b1;
    end
  end

  task automatic push_seq(input logic [6:0] idx, input logic [1:0] mtag, input logic [1:0] vtag,
                          input logic dirty, input logic [6:0] moff, input int lat);
    logic [6:0] st;
    logic [6:0] off;
    ev_t e;
    st = moff;
`ifndef RETRO_CACHE_CRITICAL_WORD_FIRST_EN
    st = 7'd0;
`endif
    e.lat = 0;
    if (dirty) begin
      for (int i = 0; i < 128; i++) begin
        off    = st + 7'(i);
        e.kind = 0;
        e.addr = {vtag, idx, off};
        e.data = bram[{idx, off}];
        q.push_back(e);
      end
    end
    for (int i = 0; i < 128; i++) begin
      off    = st + 7'(i);
      e.kind = 1;
      e.addr = {mtag, idx, off};
      e.data = src_byte(e.addr);
      q.push_back(e);
      e.kind = 2;
      e.addr = {2'b00, idx, off};
      q.push_back(e);
    end
    e.kind = 3;
    e.addr = {9'd0, idx};
    e.data = {6'd0, mtag};
    e.lat  = lat;
    q.push_back(e);
  endtask

  task automatic run_miss(input logic [6:0] idx, input logic [1:0] mtag, input logic [1:0] vtag,
                          input logic vvalid, input logic vdirty, input logic [6:0] moff, input int lat);
    push_seq(idx, mtag, vtag, vvalid && vdirty, moff, lat);
    @(negedge Clk);
    MissIndex   = idx;
    MissTag     = mtag;
    MissOffset  = moff;
    VictimTag   = vtag;
    VictimValid = vvalid;
    VictimDirty = vdirty;
    MissReq     = 1'b1;
    @(negedge Clk);
    MissReq     = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || Delay) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    if (q.size() != 0 || Delay) begin
      n_fail++;
      $display("FAIL drain: %0d events pending, Delay=%b, expected 0 pending and Delay=0", q.size(), Delay);
      q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_Delay"}, int'(Delay), 0);
    chk({tag, "_Done"}, int'(Done), 0);
    chk({tag, "_TagWrite"}, int'(TagWrite), 0);
    chk({tag, "_TagIndex"}, int'(TagIndex), 0);
    chk({tag, "_TagValue"}, int'(TagValue), 0);
    chk({tag, "_SrcAddress"}, int'(SrcAddress), 0);
    chk({tag, "_SrcAccess"}, int'(SrcAccess), 0);
    chk({tag, "_SrcWrite"}, int'(SrcWrite), 0);
    chk({tag, "_SrcDout"}, int'(SrcDout), 0);
    chk({tag, "_StoAddress"}, int'(StoAddress), 0);
    chk({tag, "_StoAccess"}, int'(StoAccess), 0);
    chk({tag, "_StoWrite"}, int'(StoWrite), 0);
    chk({tag, "_StoDout"}, int'(StoDout), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < 16384; a++) bram[a] = 8'(a * 13 + 7) ^ 8'(a >> 7);
    Reset = 1'b1; MissReq = 1'b0; MissTag = '0; MissIndex = '0; MissOffset = '0;
    VictimValid = 1'b0; VictimDirty = 1'b0; VictimTag = '0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b0;

    // Clean miss, zero-wait source
    run_miss(7'd5, 2'd3, 2'd0, 1'b0, 1'b0, 7'd0, 257);
    drain(2000);

    // Dirty victim: writeback then fill
    run_miss(7'd2, 2'd0, 2'd1, 1'b1, 1'b1, 7'd0, 513);
    drain(2000);

    // Valid but clean victim skips writeback
    run_miss(7'd9, 2'd2, 2'd1, 1'b1, 1'b0, 7'd0, 257);
    drain(2000);

    // Three source wait states per byte
    wait_states = 3;
    run_miss(7'd7, 2'd1, 2'd0, 1'b0, 1'b0, 7'd0, 641);
    drain(3000);
    wait_states = 0;

    // Reset during fill byte 40, then restart
    run_miss(7'd11, 2'd2, 2'd0, 1'b0, 1'b0, 7'd0, 257);
    n = 0;
    while (!(SrcAccess && !SrcWrite && SrcAddress[6:0] == 7'd40) && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_byte40", int'(SrcAccess && !SrcWrite && SrcAddress[6:0] == 7'd40), 1);
    #2;
    Reset = 1'b1;
    q.delete();
    @(negedge Clk);
    check_all_zero("abort");
    Reset = 1'b0;
    run_miss(7'd11, 2'd2, 2'd0, 1'b0, 1'b0, 7'd0, 257);
    drain(2000);

    // Missed offset 0x7E: critical byte first when enabled, ascending otherwise
    run_miss(7'd12, 2'd3, 2'd0, 1'b0, 1'b0, 7'h7E, 257);
    drain(2000);

    // MissReq held across COMMIT: one Done, one idle cycle, then a second sequence
    push_seq(7'd13, 2'd1, 2'd0, 1'b0, 7'd0, 257);
    push_seq(7'd13, 2'd1, 2'd0, 1'b0, 7'd0, 257);
    @(negedge Clk);
    MissIndex = 7'd13; MissTag = 2'd1; MissOffset = 7'd0;
    VictimTag = 2'd0; VictimValid = 1'b0; VictimDirty = 1'b0;
    MissReq = 1'b1;
    n = 0;
    while (!Done && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    chk("held_first_done", int'(Done), 1);
    @(negedge Clk);
    @(negedge Clk);
    chk("held_restart_delay", int'(Delay), 1);
    MissReq = 1'b0;
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
